// File: rtl/sparse_ia_packer.sv
// ============================================================================
// sparse_ia_packer : packs one dense IA pixel into a zero-skipped PE bundle
// Revision 1.0
// ============================================================================
`default_nettype none

module sparse_ia_packer #(
  parameter int CH    = 32,
  parameter int DW    = 16,
  parameter int CW    = 5,
  parameter int LANES = 32,
  parameter int HW    = 6,
  localparam int LW   = $clog2(CH) + 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic signed [DW-1:0]         i_in_data,
  input  logic        [HW-1:0]         i_h,
  input  logic        [HW-1:0]         i_w,
  output logic                         o_valid,
  input  logic                         i_ack,
  output logic        [HW:0]           o_ia_h,
  output logic        [HW:0]           o_ia_w,
  output logic        [CH-1:0][DW-1:0] o_ia_data,
  output logic        [CH-1:0][CW-1:0] o_ia_c_idx,
  output logic        [LW-1:0]         o_ia_len,
  output logic        [LW-1:0]         o_ia_iters
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t                  state_q;
  logic [LW-1:0]           ch_cnt_q;
  logic [LW-1:0]           len_q;
  logic [LW-1:0]           iters_q;
  logic                    valid_q;
  logic [HW:0]             h_q;
  logic [HW:0]             w_q;
  logic [CH-1:0][DW-1:0]   data_q;
  logic [CH-1:0][CW-1:0]   cidx_q;

  logic                    accept;
  logic                    nonzero;
  logic                    last_ch;
  logic [LW-1:0]           ch_cnt_d;
  logic [LW-1:0]           len_d;
  logic [LW-1:0]           iters_d;
  logic [CW-1:0]           cidx_d;

  assign o_in_ready = (state_q != S_HOLD);

  always_comb begin
    accept   = i_in_valid && (state_q != S_HOLD);
    nonzero  = (i_in_data != '0);
    last_ch  = (ch_cnt_q == LW'(CH - 1));
    ch_cnt_d = ch_cnt_q + 1'b1;
    len_d    = nonzero ? (len_q + 1'b1) : len_q;
    cidx_d   = CW'(ch_cnt_q);
    // iteration count is "minus one" encoded, so an empty bundle still reports 0
    iters_d  = (len_d == '0) ? '0 : LW'((int'(len_d) - 1) / LANES);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      ch_cnt_q <= '0;
      len_q    <= '0;
      iters_q  <= '0;
      valid_q  <= 1'b0;
      h_q      <= '0;
      w_q      <= '0;
      data_q   <= '0;
      cidx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (accept) begin
            for (int i = 0; i < CH; i++) begin
              if (nonzero && (len_q == LW'(i))) begin
                data_q[i] <= i_in_data;
                cidx_q[i] <= cidx_d;
              end
            end
            len_q    <= len_d;
            ch_cnt_q <= ch_cnt_d;
            if (state_q == S_IDLE) begin
              h_q <= {1'b0, i_h};
              w_q <= {1'b0, i_w};
            end
            if (last_ch) begin
              state_q <= S_HOLD;
              valid_q <= 1'b1;
              iters_q <= iters_d;
            end else begin
              state_q <= S_COLLECT;
            end
          end
        end
        S_HOLD: begin
          if (i_ack) begin
            state_q  <= S_IDLE;
            ch_cnt_q <= '0;
            len_q    <= '0;
            iters_q  <= '0;
            valid_q  <= 1'b0;
            h_q      <= '0;
            w_q      <= '0;
            data_q   <= '0;
            cidx_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_valid    = valid_q;
  assign o_ia_h     = h_q;
  assign o_ia_w     = w_q;
  assign o_ia_data  = data_q;
  assign o_ia_c_idx = cidx_q;
  assign o_ia_len   = len_q;
  assign o_ia_iters = iters_q;

endmodule

`default_nettype wire

// File: tb/tb_sparse_ia_packer.sv
// ============================================================================
// tb_sparse_ia_packer : randomized scoreboard bench for sparse_ia_packer
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sparse_ia_packer;

  localparam int CH    = 32;
  localparam int DW    = 16;
  localparam int CW    = 5;
  localparam int LANES = 8;
  localparam int HW    = 6;
  localparam int LW    = $clog2(CH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [DW-1:0]  in_data;
  logic [HW-1:0]         h_in, w_in;
  logic                  valid;
  logic                  ack;
  logic [HW:0]           ia_h, ia_w;
  logic [CH-1:0][DW-1:0] ia_data;
  logic [CH-1:0][CW-1:0] ia_cidx;
  logic [LW-1:0]         ia_len, ia_iters;

  always #5 clk = ~clk;

  sparse_ia_packer #(.CH(CH), .DW(DW), .CW(CW), .LANES(LANES), .HW(HW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .i_h        (h_in),
    .i_w        (w_in),
    .o_valid    (valid),
    .i_ack      (ack),
    .o_ia_h     (ia_h),
    .o_ia_w     (ia_w),
    .o_ia_data  (ia_data),
    .o_ia_c_idx (ia_cidx),
    .o_ia_len   (ia_len),
    .o_ia_iters (ia_iters)
  );

  typedef struct packed {
    logic [HW:0]           h;
    logic [HW:0]           w;
    logic [LW-1:0]         len;
    logic [LW-1:0]         iters;
    logic [CH-1:0][DW-1:0] data;
    logic [CH-1:0][CW-1:0] cidx;
  } bundle_t;

  bundle_t exp_q[$];
  int      rise_cyc[$];
  int      pix[CH];
  int      checks = 0;
  int      errors = 0;
  int      cyc    = 0;
  bit      mon_en = 1'b0;
  bit      ack_first = 1'b0;
  bit      ack_long  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: list the nonzero channels in order; everything else is zero.
  function automatic bundle_t model_pixel(input logic [HW-1:0] h, input logic [HW-1:0] w);
    bundle_t b;
    int n;
    b = '0;
    b.h = {1'b0, h};
    b.w = {1'b0, w};
    n = 0;
    for (int c = 0; c < CH; c++) begin
      if (pix[c] != 0) begin
        b.data[n] = DW'(pix[c]);
        b.cidx[n] = CW'(c);
        n++;
      end
    end
    b.len   = LW'(n);
    b.iters = (n == 0) ? '0 : LW'((n - 1) / LANES);
    return b;
  endfunction

  task automatic check_bundle(input bundle_t e, input string tag);
    chk({tag, " h"}, int'(ia_h), int'(e.h));
    chk({tag, " w"}, int'(ia_w), int'(e.w));
    chk({tag, " len"}, int'(ia_len), int'(e.len));
    chk({tag, " iters"}, int'(ia_iters), int'(e.iters));
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("%s data[%0d]", tag, i), int'($signed(ia_data[i])), int'($signed(e.data[i])));
      chk($sformatf("%s cidx[%0d]", tag, i), int'(ia_cidx[i]), int'(e.cidx[i]));
    end
  endtask

  task automatic check_zero(input string tag);
    bundle_t z;
    z = '0;
    chk({tag, " valid"}, int'(valid), 0);
    chk({tag, " ready"}, int'(in_ready), 1);
    check_bundle(z, tag);
  endtask

  // Monitor: pop on each new bundle, then re-check it every HOLD cycle for stability.
  initial begin : monitor
    bundle_t cur;
    bit prev;
    cur  = '0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (valid) begin
          if (!prev) begin
            rise_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_bundle actual=valid required=no_bundle");
            end else begin
              cur = exp_q.pop_front();
            end
          end
          check_bundle(cur, prev ? "hold" : "bundle");
        end
        chk("ready_vs_valid", int'(in_ready), int'(!valid));
        prev = valid;
      end
    end
  end

  // Consumer: random ack latency while holding, random (ignored) ack otherwise.
  initial begin : consumer
    int hc;
    int aw;
    ack = 1'b0;
    hc  = 0;
    aw  = 0;
    forever begin
      @(negedge clk);
      if (valid) begin
        ack = (hc == aw);
        hc++;
      end else begin
        ack = ack_first ? 1'b0 : 1'($urandom_range(0, 1));
        hc  = 0;
        aw  = ack_first ? 0 : (ack_long ? 10 : int'($urandom_range(0, 3)));
      end
    end
  end

  task automatic drive_sample(input int d, input int gap_pct);
    int to;
    if (int'($urandom_range(0, 99)) < gap_pct) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        in_data = DW'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = DW'(d);
    to = 0;
    while (!in_ready && to < 100) begin
      @(negedge clk);
      to++;
    end
    if (to >= 100) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=stalled required=ready");
    end
    @(negedge clk);
  endtask

  task automatic send_pixel(input logic [HW-1:0] h, input logic [HW-1:0] w, input int gap_pct);
    exp_q.push_back(model_pixel(h, w));
    h_in = h;
    w_in = w;
    for (int c = 0; c < CH; c++) begin
      drive_sample(pix[c], gap_pct);
      if (c == 0) begin
        h_in = HW'($urandom);
        w_in = HW'($urandom);
      end
    end
  endtask

  function automatic int rand_nz();
    int v;
    v = int'($signed(16'($urandom)));
    if (v == 0) v = 1;
    return v;
  endfunction

  task automatic randomize_pixel(input int dens);
    for (int c = 0; c < CH; c++)
      pix[c] = (int'($urandom_range(0, 99)) < dens) ? rand_nz() : 0;
  endtask

  task automatic wait_idle();
    int to;
    in_valid = 1'b0;
    to = 0;
    while ((exp_q.size() != 0 || valid) && to < 2000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 2000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=pending%0d required=0", exp_q.size());
    end
  endtask

  initial begin : stimulus
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    h_in     = '0;
    w_in     = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_zero("reset");
    mon_en = 1'b1;

    for (int c = 0; c < CH; c++) pix[c] = 0;
    send_pixel(6'd3, 6'd5, 0);
    for (int c = 0; c < CH; c++) pix[c] = c + 1;
    send_pixel(6'd10, 6'd20, 0);
    for (int c = 0; c < CH; c++) pix[c] = 0;
    pix[2] = -7; pix[17] = 100; pix[31] = 1;
    send_pixel(6'd63, 6'd0, 0);
    wait_idle();

    // long consumer stall with 50% input gaps
    ack_long = 1'b1;
    for (int p = 0; p < 3; p++) begin
      randomize_pixel(40);
      send_pixel(HW'($urandom), HW'($urandom), 50);
    end
    wait_idle();
    ack_long = 1'b0;

    // back-to-back pixels, ack on the first HOLD cycle, no input gaps
    ack_first = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rise_cyc.delete();
    for (int c = 0; c < CH; c++) pix[c] = (c < 20) ? (c - 60) : 0;
    for (int k = 0; k < 64; k++) begin
      int a, b, t;
      a = int'($urandom_range(0, CH - 1));
      b = int'($urandom_range(0, CH - 1));
      t = pix[a]; pix[a] = pix[b]; pix[b] = t;
    end
    send_pixel(6'd7, 6'd9, 0);
    randomize_pixel(10);
    send_pixel(6'd1, 6'd2, 0);
    for (int c = 0; c < CH; c++) pix[c] = (c % 3 == 0) ? rand_nz() : 0;
    send_pixel(6'd4, 6'd8, 0);
    wait_idle();
    chk("b2b_bundles", rise_cyc.size(), 3);
    // CH accepts (channel 0 taken in IDLE) plus the single HOLD cycle
    if (rise_cyc.size() == 3) begin
      chk("b2b_period0", rise_cyc[1] - rise_cyc[0], CH + 1);
      chk("b2b_period1", rise_cyc[2] - rise_cyc[1], CH + 1);
    end
    ack_first = 1'b0;

    // reset after 12 accepts discards the partial pixel
    for (int c = 0; c < 12; c++) drive_sample(c + 1000, 30);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("midreset");
    randomize_pixel(50);
    send_pixel(6'd33, 6'd44, 0);
    wait_idle();

    for (int p = 0; p < 15; p++) begin
      randomize_pixel(int'($urandom_range(0, 100)));
      send_pixel(HW'($urandom), HW'($urandom), int'($urandom_range(0, 60)));
    end
    wait_idle();
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
